// File: rtl/phy_pkg.sv
// Shared PHY definitions: line symbols, byte width and the serial TX lane state.
package phy_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_SYM  = 8'h7C;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } tx_state_t;

endpackage

// File: rtl/par_serial_tx.sv
// Per-lane byte-to-serial transmitter: COMMA training after reset, then
// MSB-first data bytes with IDLE fill, one bit per clk.
// Optional macro PAR_SERIAL_TX_STATS_EN adds a saturating data_count output.
module par_serial_tx
  import phy_pkg::*;
#(
  parameter int unsigned        N_COMMA = 4,
  parameter logic [BYTE_W-1:0]  COMMA   = COMMA_SYM,
  parameter logic [BYTE_W-1:0]  IDLE    = IDLE_SYM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_serial_out,
  output logic              byte_start,
  output logic              lane_active
`ifdef PAR_SERIAL_TX_STATS_EN
  ,
  output logic [15:0]       data_count
`endif
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned COMMA_W = 4;

  tx_state_t          state_q;
  tx_state_t          state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-1:0]  shreg_q;
  logic [COMMA_W-1:0] comma_cnt_q;
  logic [COMMA_W-1:0] comma_cnt_d;
  logic [BYTE_W-1:0]  byte_sel;
  logic               boundary;
  logic               accept;

  assign boundary  = (bit_cnt_q == '0);
  // Reset wins over a boundary so nothing is accepted while it is held.
  assign ready_out = (state_q == ACTIVE) && boundary && !reset;
  assign accept    = valid_in && ready_out;

  // Next-state, COMMA counting and byte selection for the next boundary.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    byte_sel    = IDLE;
    case (state_q)
      TRAIN: begin
        byte_sel = COMMA;
        if (boundary) begin
          if (comma_cnt_q < COMMA_W'(N_COMMA)) begin
            comma_cnt_d = comma_cnt_q + COMMA_W'(1);
          end
          if (comma_cnt_q == COMMA_W'(N_COMMA - 1)) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        byte_sel = valid_in ? data_in : IDLE;
      end
      default: begin
        state_d = TRAIN;
      end
    endcase
  end

  // State and COMMA counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TRAIN;
      comma_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  // Bit counter, shift register and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      data_serial_out <= 1'b0;
      byte_start      <= 1'b0;
      lane_active     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
      lane_active <= (state_d == ACTIVE);
      if (boundary) begin
        shreg_q         <= byte_sel;
        data_serial_out <= byte_sel[BYTE_W-1];
        byte_start      <= 1'b1;
      end else begin
        data_serial_out <= shreg_q[CNT_W'(BYTE_W - 1) - bit_cnt_q];
        byte_start      <= 1'b0;
      end
    end
  end

`ifdef PAR_SERIAL_TX_STATS_EN
  // Saturating count of accepted data bytes; IDLE and COMMA are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_count <= '0;
    end else if (accept && (data_count != 16'hFFFF)) begin
      data_count <= data_count + 16'd1;
    end
  end
`else
  // Without statistics the accept strobe only qualifies ready_out handshakes.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_par_serial_tx.sv
// Self-checking bench for par_serial_tx; expected serial bits are queued when
// a byte is loaded and popped one per clock as the DUT shifts them out.
module tb_par_serial_tx;

  localparam int unsigned N_COMMA = 4;
  localparam logic [7:0]  COMMA_B = 8'hBC;
  localparam logic [7:0]  IDLE_B  = 8'h7C;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_serial_out;
  logic       byte_start;
  logic       lane_active;
`ifdef PAR_SERIAL_TX_STATS_EN
  logic [15:0] data_count;
`endif

  par_serial_tx #(
    .N_COMMA (N_COMMA),
    .COMMA   (COMMA_B),
    .IDLE    (IDLE_B)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .data_serial_out (data_serial_out),
    .byte_start      (byte_start),
    .lane_active     (lane_active)
`ifdef PAR_SERIAL_TX_STATS_EN
    ,
    .data_count      (data_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] exp_count = '0;
  logic [1:0]  exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check ready_out, queue expected bits at a
  // boundary, then compare the registered outputs after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    logic       bnd;
    logic       trained;
    logic [7:0] b;
    logic [1:0] e;
    valid_in = v;
    data_in  = d;
    #1;
    bnd     = (cyc % 8 == 0);
    trained = (cyc >= 8 * N_COMMA);
    check("ready_out", 16'(ready_out), 16'(bnd && trained));
    if (bnd) begin
      b = !trained ? COMMA_B : (v ? d : IDLE_B);
      for (int i = 7; i >= 0; i--) exp_q.push_back({i == 7, b[i]});
      if (trained && v && exp_count != 16'hFFFF) exp_count++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("queue_empty", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check("serial_bit", 16'(data_serial_out), 16'(e[0]));
      check("byte_start", 16'(byte_start), 16'(e[1]));
    end
    check("lane_active", 16'(lane_active), 16'(cyc > 8 * (N_COMMA - 1)));
`ifdef PAR_SERIAL_TX_STATS_EN
    check("data_count", data_count, exp_count);
`endif
  endtask

  task automatic steps(input int n, input logic v, input logic [7:0] d);
    for (int i = 0; i < n; i++) step(v, d);
  endtask

  // Hold reset for n clocks; partially sent bytes are discarded.
  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    check("ready_in_reset", 16'(ready_out), 16'd0);
    repeat (n) @(posedge clk);
    #1;
    check("rst_serial", 16'(data_serial_out), 16'd0);
    check("rst_byte_start", 16'(byte_start), 16'd0);
    check("rst_lane_active", 16'(lane_active), 16'd0);
`ifdef PAR_SERIAL_TX_STATS_EN
    check("rst_data_count", data_count, 16'd0);
`endif
    reset = 1'b0;
    exp_q.delete();
    cyc       = 0;
    exp_count = '0;
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Training: four COMMAs, then IDLE fill.
    steps(48, 1'b0, 8'h00);

    // Held A5: one transfer per byte period.
    steps(24, 1'b1, 8'hA5);

    // Back-to-back bytes with no gap bits.
    steps(8, 1'b1, 8'h01);
    steps(8, 1'b1, 8'hFF);
    steps(8, 1'b1, 8'h00);

    // valid_in pulsed away from the boundary is ignored; IDLE follows.
    steps(3, 1'b0, 8'h00);
    step(1'b1, 8'h55);
    steps(12, 1'b0, 8'h00);

    // Align to a boundary, start a data byte, reset at bit_cnt=4.
    while (cyc % 8 != 0) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    steps(3, 1'b0, 8'h00);
    valid_in = 1'b1;
    do_reset(1);
    steps(40, 1'b1, 8'h96);

    // Reset asserted on a boundary with valid data offered.
    while (cyc % 8 != 0) step(1'b0, 8'h00);
    valid_in = 1'b1;
    data_in  = 8'hC3;
    do_reset(1);
    steps(32, 1'b0, 8'h00);

    // Ten data bytes interleaved with idle bytes.
    for (int i = 0; i < 10; i++) begin
      steps(8, 1'b1, 8'(8'h11 * (i + 1)));
      steps(8, 1'b0, 8'h00);
    end
`ifdef PAR_SERIAL_TX_STATS_EN
    check("count_ten", data_count, 16'd10);
    force dut.data_count = 16'hFFFF;
    #1;
    release dut.data_count;
    exp_count = 16'hFFFF;
`endif
    steps(8, 1'b1, 8'h5A);
    steps(8, 1'b0, 8'h00);
`ifdef PAR_SERIAL_TX_STATS_EN
    check("count_saturated", data_count, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
